two_to_one_mux: RTL and testbench

//   Two-input, one-select multiplexer: Out = sel ? in1 : in0.

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_bit.sv | 15 +
 rtl/two_to_one_mux.sv | 56 +++++
 tb/tb_two_to_one_mux.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and defaults for the two_to_one_mux datapath slice.
package mux_pkg;

  localparam int unsigned MUX_WIDTH_DEFAULT = 1;

  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } mux_sel_e;

  // Plain ?: so an X/Z select propagates exactly as the language defines it.
  function automatic logic mux_pick(input logic sel, input logic a0, input logic a1);
    return sel ? a1 : a0;
  endfunction

endpackage

// File: rtl/mux_bit.sv
// Single-bit combinational 2:1 mux cell; replicated per bit by two_to_one_mux.
module mux_bit
  import mux_pkg::*;
(
  input  logic in0,
  input  logic in1,
  input  logic sel,
  output logic out
);

  always_comb begin
    out = mux_pick(sel, in0, in1);
  end

endmodule

// File: rtl/two_to_one_mux.sv
// WIDTH-bit 2:1 mux with combinational Out plus a registered copy (out_q) tagged by sel_q.
// Optional simulation-only X/consistency checks are enabled with the MUX_XCHECK_EN macro.
module two_to_one_mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q
);

  logic [WIDTH-1:0] out_d;
  mux_sel_e         sel_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_bit u_mux_bit (
      .in0 (in0[i]),
      .in1 (in1[i]),
      .sel (sel),
      .out (Out[i])
    );
  end

  always_comb begin
    out_d = Out;
    sel_d = mux_sel_e'(sel);
  end

  // Out stays live through reset; only the registered copy is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      sel_q <= SEL_IN0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end

`ifdef MUX_XCHECK_EN
  sel_known_a: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(sel))
    else $error("two_to_one_mux: sel is X/Z");

  out_consistent_a: assert property (@(posedge clk) disable iff (!rst_n)
                                     Out === (sel ? in1 : in0))
    else $error("two_to_one_mux: Out disagrees with sel ? in1 : in0");
`else
`endif

endmodule

// File: tb/tb_two_to_one_mux.sv
// Scoreboard bench for two_to_one_mux at WIDTH=1 and WIDTH=8 sharing one clock/reset.
module tb_two_to_one_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in0, a_in1, a_sel, a_out, a_outq, a_selq;
  logic [7:0] b_in0, b_in1, b_out, b_outq;
  logic       b_sel, b_selq;

  two_to_one_mux #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in0(a_in0), .in1(a_in1), .sel(a_sel),
    .Out(a_out), .out_q(a_outq), .sel_q(a_selq)
  );

  two_to_one_mux #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in0(b_in0), .in1(b_in1), .sel(b_sel),
    .Out(b_out), .out_q(b_outq), .sel_q(b_selq)
  );

  typedef struct {
    logic       a_out;
    logic       a_sel;
    logic [7:0] b_out;
    logic       b_sel;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  // Truth table indexed by {in1,in0,sel}.
  localparam logic [7:0] TRUTH = 8'b1110_0100;

  function automatic logic ref_w1(input logic i1, input logic i0, input logic s);
    logic [7:0] t;
    t = TRUTH;
    return t[{i1, i0, s}];
  endfunction

  function automatic logic [7:0] ref_w8(input logic [7:0] w0, input logic [7:0] w1, input logic s);
    return (w0 & ~{8{s}}) | (w1 & {8{s}});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic i1, input logic i0, input logic s,
                       input logic [7:0] w0, input logic [7:0] w1, input logic ws,
                       input bit push);
    exp_t e;
    a_in1 = i1; a_in0 = i0; a_sel = s;
    b_in0 = w0; b_in1 = w1; b_sel = ws;
    #1;
    check("out_w1", 64'(a_out), 64'(ref_w1(i1, i0, s)));
    check("out_w8", 64'(b_out), 64'(ref_w8(w0, w1, ws)));
    if (push) begin
      e.a_out = ref_w1(i1, i0, s);
      e.a_sel = s;
      e.b_out = ref_w8(w0, w1, ws);
      e.b_sel = ws;
      sb.push_back(e);
    end
  endtask

  // Monitor: registered outputs are sampled 1 unit after each rising edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (!rst_n) begin
        check("rst_outq_w1", 64'(a_outq), 64'd0);
        check("rst_selq_w1", 64'(a_selq), 64'd0);
        check("rst_outq_w8", 64'(b_outq), 64'd0);
        check("rst_selq_w8", 64'(b_selq), 64'd0);
      end else if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underrun: got empty queue expected an entry at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        check("outq_w1", 64'(a_outq), 64'(e.a_out));
        check("selq_w1", 64'(a_selq), 64'(e.a_sel));
        check("outq_w8", 64'(b_outq), 64'(e.b_out));
        check("selq_w8", 64'(b_selq), 64'(e.b_sel));
      end
    end
  end

  initial begin
    logic [2:0] dir_vec [8] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011, 3'b000, 3'b001};
    logic       dir_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] v;
    logic       s;

    // Held in reset: Out live, registers cleared.
    apply(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_out_live_w1", 64'(a_out), 64'd1);

    rst_n = 1'b1;
    apply(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1);

    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      v = 3'(k);
      apply(v[2], v[1], v[0], 8'hA5, 8'h3C, v[0], 1'b1);
    end

    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      v = dir_vec[k];
      apply(v[2], v[1], v[0], 8'hA5, 8'h3C, v[0], 1'b1);
      check("directed_out", 64'(a_out), 64'(dir_exp[k]));
    end

    // sel toggles every cycle.
    s = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      @(negedge clk);
      s = ~s;
      apply(1'($urandom), 1'($urandom), s, 8'($urandom), 8'($urandom), ~s, 1'b1);
    end

    for (int unsigned k = 0; k < 200; k++) begin
      @(negedge clk);
      apply(1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    // Mid-operation reset between clock edges.
    @(negedge clk);
    apply(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    apply(1'b1, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0);
    #1;
    check("pre_rst_outq_w1", 64'(a_outq), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_outq_w1", 64'(a_outq), 64'd0);
    check("async_selq_w1", 64'(a_selq), 64'd0);
    check("async_outq_w8", 64'(b_outq), 64'd0);
    check("async_selq_w8", 64'(b_selq), 64'd0);
    check("rst_out_live_w1b", 64'(a_out), 64'd1);
    check("rst_out_live_w8", 64'(b_out), 64'h5A);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1);

    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      apply(1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    @(posedge clk);
    #2;
    done = 1'b1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
